// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU word/opcode plus the bring-up harness state and history entry.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } hst_state_t;

  typedef struct packed {
    aluop_t     op;
    logic [2:0] nzv;
    word_t      result;
  } hist_entry_t;

  localparam int NUM_KEYS  = 4;
  localparam int KEY_ADV   = 0;
  localparam int KEY_ABORT = 1;
  localparam int KEY_OLDER = 2;
  localparam int KEY_NEWER = 3;
endpackage

// File: rtl/key_debounce.sv
// Single push-button debouncer: synchronises the raw level, accepts a new level
// after DEBOUNCE_CYCLES stable differing cycles, and pulses on accepted presses.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK,
  input  logic nRST,
  input  logic key_n,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]       sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        // only a released->pressed flip produces an event
        press <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_fpga_harness.sv
// Board bring-up harness: debounced keys step load-A/B/op/exec into one ALU and log
// results in a browsable history. SIGN_EXT_EN selects sign- instead of zero-extension.
module alu_fpga_harness
  import cpu_types_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int HIST_DEPTH      = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [DATA_W-1:0]           sw_data,
  input  logic [3:0]                  key_n,
  output logic [31:0]                 alu_port_a,
  output logic [31:0]                 alu_port_b,
  output aluop_t                      alu_aluop,
  input  logic [31:0]                 alu_port_o,
  input  logic [2:0]                  alu_nzv,
  output logic [DATA_W-1:0]           led_data,
  output logic [2:0]                  led_flags,
  output logic [2:0]                  led_state,
  output logic [$clog2(HIST_DEPTH)-1:0] led_hist_idx,
  output logic [$clog2(HIST_DEPTH):0]   led_hist_cnt
);
  localparam int IDX_W = $clog2(HIST_DEPTH);

  hst_state_t          state;
  logic [NUM_KEYS-1:0] press;
  hist_entry_t         hist [HIST_DEPTH];
  logic [IDX_W-1:0]    wr_ptr, view, oldest, newest;
  logic [IDX_W:0]      cnt;
  logic                ev_abort, ev_adv, ev_older, ev_newer;
  logic [3:0]          op_bits;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_KEYS-1:0] (
    .CLK   (CLK),
    .nRST  (nRST),
    .key_n (key_n),
    .press (press)
  );

  // strict priority: only the highest pending event survives
  assign ev_abort = press[KEY_ABORT];
  assign ev_adv   = press[KEY_ADV] & ~press[KEY_ABORT];
  assign ev_older = press[KEY_OLDER] & ~press[KEY_ABORT] & ~press[KEY_ADV];
  assign ev_newer = press[KEY_NEWER] & ~press[KEY_ABORT] & ~press[KEY_ADV] & ~press[KEY_OLDER];

  assign newest = wr_ptr - 1'b1;
  assign oldest = (cnt == (IDX_W+1)'(HIST_DEPTH)) ? wr_ptr : '0;

  always_comb begin
    op_bits = '0;
    for (int i = 0; i < 4 && i < DATA_W; i++) op_bits[i] = sw_data[i];
  end

  function automatic word_t ext(input logic [DATA_W-1:0] d);
    word_t w;
    w = '0;
    w[DATA_W-1:0] = d;
`ifdef SIGN_EXT_EN
    for (int i = DATA_W; i < 32; i++) w[i] = d[DATA_W-1];
`endif
    return w;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= S_LOAD_A;
      alu_port_a <= '0;
      alu_port_b <= '0;
      alu_aluop  <= aluop_t'(4'd0);
      wr_ptr     <= '0;
      cnt        <= '0;
      view       <= '0;
    end else if (ev_abort && state != S_EXEC) begin
      state <= S_LOAD_A;
    end else begin
      case (state)
        S_LOAD_A: if (ev_adv) begin
          alu_port_a <= ext(sw_data);
          state      <= S_LOAD_B;
        end
        S_LOAD_B: if (ev_adv) begin
          alu_port_b <= ext(sw_data);
          state      <= S_LOAD_OP;
        end
        S_LOAD_OP: if (ev_adv) begin
          alu_aluop <= aluop_t'(op_bits);
          state     <= S_EXEC;
        end
        S_EXEC: begin
          wr_ptr <= wr_ptr + 1'b1;
          view   <= wr_ptr;
          if (cnt != (IDX_W+1)'(HIST_DEPTH)) cnt <= cnt + 1'b1;
          state  <= S_SHOW;
        end
        S_SHOW: begin
          if (ev_adv)                             state <= S_LOAD_A;
          else if (ev_older && view != oldest) view  <= view - 1'b1;
          else if (ev_newer && view != newest) view  <= view + 1'b1;
        end
        default: state <= S_LOAD_A;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
    end else if (state == S_EXEC) begin
      hist[wr_ptr] <= '{op: alu_aluop, nzv: alu_nzv, result: alu_port_o};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      led_data     <= '0;
      led_flags    <= '0;
      led_state    <= '0;
      led_hist_idx <= '0;
      led_hist_cnt <= '0;
    end else begin
      if (state == S_EXEC || state == S_SHOW) begin
        led_data  <= hist[view].result[DATA_W-1:0];
        led_flags <= hist[view].nzv;
      end else begin
        led_data  <= sw_data;
        led_flags <= '0;
      end
      led_state    <= state;
      led_hist_idx <= view;
      led_hist_cnt <= cnt;
    end
  end
endmodule

// File: tb/tb_alu_fpga_harness.sv
// Self-checking bench for alu_fpga_harness with a behavioural ALU stub and history model.
module tb_alu_fpga_harness;
  import cpu_types_pkg::*;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic [DATA_W-1:0] sw = '0;
  logic [3:0]        key_n = 4'hF;
  logic [31:0]       port_a, port_b, port_o;
  aluop_t            aluop;
  logic [2:0]        nzv;
  logic [DATA_W-1:0] led_data;
  logic [2:0]        led_flags, led_state;
  logic [2:0]        led_hist_idx;
  logic [3:0]        led_hist_cnt;

  int checks = 0;
  int errors = 0;

  logic [34:0] hq[$];
  int          vp;
  int          wcount;
  logic [31:0] exp_a, exp_b;
  aluop_t      exp_op;
  bit          in_show;

  always #5 clk = ~clk;

  alu_fpga_harness #(.DATA_W(DATA_W), .HIST_DEPTH(DEPTH), .DEBOUNCE_CYCLES(4)) dut (
    .CLK(clk), .nRST(nrst), .sw_data(sw), .key_n(key_n),
    .alu_port_a(port_a), .alu_port_b(port_b), .alu_aluop(aluop),
    .alu_port_o(port_o), .alu_nzv(nzv),
    .led_data(led_data), .led_flags(led_flags), .led_state(led_state),
    .led_hist_idx(led_hist_idx), .led_hist_cnt(led_hist_cnt)
  );

  function automatic logic [34:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input aluop_t op);
    logic [31:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (op)
      ALU_ADD:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      ALU_SUB:  begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      default:  r = '0;
    endcase
    return {r[31], r == 32'd0, v, r};
  endfunction

  // ALU stub driven by the harness ports
  always_comb begin
    logic [34:0] res;
    res    = alu_ref(port_a, port_b, aluop);
    port_o = res[31:0];
    nzv    = res[34:32];
  end

  function automatic logic [31:0] ext_ref(input logic [DATA_W-1:0] x);
`ifdef SIGN_EXT_EN
    return {{(32-DATA_W){x[DATA_W-1]}}, x};
`else
    return {{(32-DATA_W){1'b0}}, x};
`endif
  endfunction

  task automatic press(input logic [3:0] mask, input int hold);
    @(negedge clk);
    key_n = ~mask;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    key_n = 4'hF;
    repeat (8) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_exec();
    hq.push_back(alu_ref(exp_a, exp_b, exp_op));
    if (hq.size() > DEPTH) void'(hq.pop_front());
    vp = hq.size() - 1;
    wcount++;
    in_show = 1'b1;
  endtask

  task automatic run_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input aluop_t op);
    if (in_show) press(4'b0001, 8);
    in_show = 1'b0;
    sw = a;  press(4'b0001, 8); exp_a = ext_ref(a);
    sw = b;  press(4'b0001, 8); exp_b = ext_ref(b);
    sw = DATA_W'(op); press(4'b0001, 8); exp_op = op;
    model_exec();
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (led_state !== 3'(S_LOAD_A)) begin errors++; $display("FAIL reset_state got %0d want %0d", led_state, S_LOAD_A); end
    checks++; if (port_a !== 32'd0 || port_b !== 32'd0) begin errors++; $display("FAIL reset_ports got %h/%h want 0", port_a, port_b); end
    checks++; if (aluop !== aluop_t'(4'd0)) begin errors++; $display("FAIL reset_op got %0d want 0", aluop); end
    checks++; if (led_hist_cnt !== 4'd0 || led_data !== '0) begin errors++; $display("FAIL reset_leds got cnt %0d data %h want 0", led_hist_cnt, led_data); end
    nrst = 1'b1;
    hq.delete(); wcount = 0; vp = 0; exp_a = 0; exp_b = 0; exp_op = aluop_t'(4'd0); in_show = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_debounce();
    sw = 16'h1234;
    @(negedge clk);
    key_n[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    key_n[0] = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    checks++; if (led_state !== 3'(S_LOAD_A)) begin errors++; $display("FAIL debounce_short got %0d want %0d", led_state, S_LOAD_A); end
    press(4'b0001, 20);
    exp_a = ext_ref(16'h1234);
    checks++; if (led_state !== 3'(S_LOAD_B)) begin errors++; $display("FAIL debounce_long got %0d want %0d", led_state, S_LOAD_B); end
    checks++; if (port_a !== exp_a) begin errors++; $display("FAIL debounce_port_a got %h want %h", port_a, exp_a); end
    checks++; if (led_data !== 16'h1234) begin errors++; $display("FAIL live_sw got %h want 1234", led_data); end
    press(4'b0010, 8);
    checks++; if (led_state !== 3'(S_LOAD_A)) begin errors++; $display("FAIL abort_to_a got %0d want %0d", led_state, S_LOAD_A); end
  endtask

  task automatic test_add();
    run_op(16'h0005, 16'h0003, ALU_ADD);
    checks++; if (port_a !== 32'd5 || port_b !== 32'd3) begin errors++; $display("FAIL add_ports got %h/%h want 5/3", port_a, port_b); end
    checks++; if (led_state !== 3'(S_SHOW)) begin errors++; $display("FAIL add_state got %0d want %0d", led_state, S_SHOW); end
    checks++; if (led_data !== 16'h0008 || led_flags !== 3'b000) begin errors++; $display("FAIL add_result got %h/%b want 0008/000", led_data, led_flags); end
    checks++; if (led_hist_cnt !== 4'd1) begin errors++; $display("FAIL add_cnt got %0d want 1", led_hist_cnt); end
  endtask

  task automatic test_sub_zero();
    logic [31:0] want_a;
`ifdef SIGN_EXT_EN
    want_a = 32'hFFFF8000;
`else
    want_a = 32'h00008000;
`endif
    run_op(16'h8000, 16'h8000, ALU_SUB);
    checks++; if (port_a !== want_a) begin errors++; $display("FAIL sub_port_a got %h want %h", port_a, want_a); end
    checks++; if (led_data !== 16'h0000 || led_flags !== 3'b010) begin errors++; $display("FAIL sub_zero got %h/%b want 0000/010", led_data, led_flags); end
  endtask

  task automatic test_random();
    aluop_t ops [6] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT};
    for (int n = 0; n < 8; n++) begin
      logic [DATA_W-1:0] a, b;
      aluop_t op;
      a  = DATA_W'($urandom);
      b  = DATA_W'($urandom);
      op = ops[$urandom_range(0, 5)];
      run_op(a, b, op);
      checks++; if (port_a !== exp_a || port_b !== exp_b || aluop !== exp_op) begin errors++; $display("FAIL rand_ports[%0d] got %h/%h/%0d want %h/%h/%0d", n, port_a, port_b, aluop, exp_a, exp_b, exp_op); end
      checks++; if (led_data !== hq[vp][DATA_W-1:0] || led_flags !== hq[vp][34:32]) begin errors++; $display("FAIL rand_result[%0d] got %h/%b want %h/%b", n, led_data, led_flags, hq[vp][DATA_W-1:0], hq[vp][34:32]); end
      checks++; if (led_hist_cnt !== 4'(hq.size())) begin errors++; $display("FAIL rand_cnt[%0d] got %0d want %0d", n, led_hist_cnt, hq.size()); end
      checks++; if (led_hist_idx !== 3'((wcount - 1) % DEPTH)) begin errors++; $display("FAIL rand_idx[%0d] got %0d want %0d", n, led_hist_idx, (wcount - 1) % DEPTH); end
    end
  endtask

  task automatic test_history();
    for (int i = 1; i <= 10; i++) begin
      int r;
      r = $urandom_range(0, i);
      run_op(DATA_W'(r), DATA_W'(i - r), ALU_ADD);
    end
    checks++; if (led_hist_cnt !== 4'd8) begin errors++; $display("FAIL hist_cnt got %0d want 8", led_hist_cnt); end
    checks++; if (led_data !== hq[vp][DATA_W-1:0]) begin errors++; $display("FAIL hist_newest got %h want %h", led_data, hq[vp][DATA_W-1:0]); end
    for (int i = 0; i < 8; i++) begin
      press(4'b0100, 8);
      if (vp > 0) vp--;
      checks++; if (led_data !== hq[vp][DATA_W-1:0]) begin errors++; $display("FAIL hist_older[%0d] got %h want %h", i, led_data, hq[vp][DATA_W-1:0]); end
    end
    checks++; if (led_data !== 16'd3) begin errors++; $display("FAIL hist_oldest got %h want 0003", led_data); end
    for (int i = 0; i < 9; i++) begin
      press(4'b1000, 8);
      if (vp < hq.size() - 1) vp++;
    end
    checks++; if (led_data !== 16'd10 || led_data !== hq[vp][DATA_W-1:0]) begin errors++; $display("FAIL hist_newer got %h want 000a", led_data); end
    // older and newer together: newer is dropped
    press(4'b1100, 8);
    if (vp > 0) vp--;
    checks++; if (led_data !== hq[vp][DATA_W-1:0]) begin errors++; $display("FAIL hist_prio got %h want %h", led_data, hq[vp][DATA_W-1:0]); end
  endtask

  task automatic test_abort();
    logic [DATA_W-1:0] a;
    int size0;
    press(4'b0001, 8); in_show = 0;
    a = DATA_W'($urandom);
    sw = a; press(4'b0001, 8); exp_a = ext_ref(a);
    sw = 16'hBEEF; press(4'b0011, 8);
    checks++; if (led_state !== 3'(S_LOAD_A) || port_b !== exp_b) begin errors++; $display("FAIL abort_adv got %0d/%h want %0d/%h", led_state, port_b, S_LOAD_A, exp_b); end
    sw = DATA_W'($urandom); press(4'b0001, 8); exp_a = ext_ref(sw);
    sw = DATA_W'($urandom); press(4'b0001, 8); exp_b = ext_ref(sw);
    sw = DATA_W'(ALU_XOR); exp_op = ALU_XOR;
    size0 = wcount;
    // abort debounces one cycle behind advance, so it lands in the exec cycle
    @(negedge clk); key_n[0] = 1'b0;
    @(negedge clk); key_n[1] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); key_n = 4'hF;
    repeat (10) @(posedge clk);
    @(negedge clk);
    model_exec();
    checks++; if (led_state !== 3'(S_SHOW)) begin errors++; $display("FAIL abort_exec_state got %0d want %0d", led_state, S_SHOW); end
    checks++; if (led_data !== hq[vp][DATA_W-1:0] || wcount != size0 + 1) begin errors++; $display("FAIL abort_exec_write got %h want %h", led_data, hq[vp][DATA_W-1:0]); end
  endtask

  task automatic test_async_reset();
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    hq.delete(); wcount = 0; in_show = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) run_op(DATA_W'($urandom), DATA_W'($urandom), ALU_ADD);
    checks++; if (led_hist_cnt !== 4'd5 || led_state !== 3'(S_SHOW)) begin errors++; $display("FAIL pre_reset got %0d/%0d want 5/%0d", led_hist_cnt, led_state, S_SHOW); end
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    checks++; if (led_state !== 3'd0 || led_hist_cnt !== 4'd0 || led_data !== '0 || led_flags !== 3'd0 || led_hist_idx !== 3'd0) begin errors++; $display("FAIL async_leds got st %0d cnt %0d data %h", led_state, led_hist_cnt, led_data); end
    checks++; if (port_a !== 32'd0 || port_b !== 32'd0 || aluop !== aluop_t'(4'd0)) begin errors++; $display("FAIL async_ports got %h/%h/%0d want 0", port_a, port_b, aluop); end
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (led_state !== 3'(S_LOAD_A) || led_hist_cnt !== 4'd0) begin errors++; $display("FAIL post_reset got %0d/%0d want %0d/0", led_state, led_hist_cnt, S_LOAD_A); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_add();
    test_sub_zero();
    test_random();
    test_history();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_fpga_harness.md
Name: alu_fpga_harness

Overview:
Sequential, parametrised FPGA bring-up harness for the combinational ALU, the successor to the switch/LED ALU board wrapper. It debounces the push-buttons and walks a load-A / load-B / load-op / execute sequence with registered operands. Each result is logged into a circular history buffer that can be browsed on the LEDs. It sits between board I/O (SW/KEY/LED) and one alu instance driven through discrete ALU ports.

Parameters:
DATA_W, 16, switch operand width (1..32); operands are extended to word_t.
HIST_DEPTH, 8, result history entries (power of 2, >=2).
DEBOUNCE_CYCLES, 500000, consecutive stable cycles before a key level is accepted (>=2).

Ports:
CLK  in  1  system clock
nRST  in  1  asynchronous active-low reset
sw_data  in  DATA_W  switch operand/opcode input
key_n  in  4  raw active-low push-buttons: [0] advance, [1] abort, [2] history older, [3] history newer
alu_port_a  out  32  registered operand A to ALU
alu_port_b  out  32  registered operand B to ALU
alu_aluop  out  aluop_t  registered opcode to ALU
alu_port_o  in  32  ALU result
alu_nzv  in  3  ALU flags {n,z,v}
led_data  out  DATA_W  display value
led_flags  out  3  displayed {n,z,v}
led_state  out  3  one-hot-free state code (hst_state_t)
led_hist_idx  out  $clog2(HIST_DEPTH)  history entry being shown
led_hist_cnt  out  $clog2(HIST_DEPTH)+1  valid history entries

Behaviour:
- Clock and reset: one clock CLK. nRST is asynchronous and active-low. All flops clear on its assertion, including mid-sequence.
- Reset values: state S_LOAD_A; alu_port_a/b = 0; alu_aluop = aluop_t'(0); history count, write pointer and view index = 0; led_* = 0 until the first clock after reset release.
- Debounce: per key, a counter runs while the raw level differs from the accepted level. The accepted level flips after DEBOUNCE_CYCLES consecutive differing cycles; any return to the accepted level zeroes the counter. A press event is a 1-cycle pulse on the accepted 1->0 transition. Release events are ignored. Accepted levels reset to 1 (released).
- Event priority, one event acted on per cycle: abort > advance > older > newer. Lower-priority events in the same cycle are dropped.
- States and transitions:
  - S_LOAD_A, advance: alu_port_a <= ext(sw_data); go to S_LOAD_B.
  - S_LOAD_B, advance: alu_port_b <= ext(sw_data); go to S_LOAD_OP.
  - S_LOAD_OP, advance: alu_aluop <= aluop_t'(sw_data[3:0]); go to S_EXEC. sw_data bits above 3 are ignored.
  - S_EXEC: unconditional single cycle. At the clock edge ending S_EXEC, write {aluop, nzv, port_o} to hist[wr_ptr]; wr_ptr++ (wraps mod HIST_DEPTH); count saturates at HIST_DEPTH; view index <= entry just written. Go to S_SHOW.
  - S_SHOW: older moves the view index back one, stopping at the oldest valid entry (no wrap past it). Newer moves it forward, stopping at the newest. Advance goes to S_LOAD_A with operands retained.
  - Abort in any state except S_EXEC goes to S_LOAD_A without changing operands or history. Abort arriving in S_EXEC is dropped; the write completes.
- Extension: ext() zero-extends DATA_W to 32 bits (see SIGN_EXT_EN).
- Display:
  - Load states: led_data = live sw_data; led_flags = 0.
  - S_EXEC and S_SHOW: led_data = hist[view].result[DATA_W-1:0]; led_flags = hist[view].nzv.
  - All display outputs are registered (1-cycle latency).
- History wrap: once full, the oldest entry is overwritten. The oldest index is wr_ptr when count == HIST_DEPTH, else 0.

Optional Feature:
SIGN_EXT_EN
- Defined: ext() sign-extends sw_data[DATA_W-1] into bits 31:DATA_W. The S_SHOW display also shows the result's sign on led_flags[2] unchanged.
- Undefined: zero extension only.
- DATA_W == 32 makes the macro a no-op.

Decomposition:
- cpu_types_pkg (shared) additions:
  - hst_state_t enum (S_LOAD_A, S_LOAD_B, S_LOAD_OP, S_EXEC, S_SHOW).
  - hist_entry_t packed struct {aluop_t op; logic [2:0] nzv; word_t result}.
- Sub-module key_debounce (param DEBOUNCE_CYCLES; CLK, nRST, key_n, press pulse), instantiated 4x.
- The history RAM is inferred in-module.

Test Plan:
- DEBOUNCE_CYCLES=4. Key0 low for 3 cycles then high -> no event, state stays S_LOAD_A. Key0 low for 4+ cycles -> exactly one advance pulse -> S_LOAD_B.
- Advance with sw=0x0005, sw=0x0003, sw=ALU_ADD -> alu_port_a=5, alu_port_b=3. One S_EXEC cycle, then S_SHOW with led_data=0x0008, led_flags=3'b000, led_hist_cnt=1.
- A=0x8000, B=0x8000 with ALU_SUB -> led_data=0, led_flags=3'b010. With SIGN_EXT_EN, alu_port_a=0xFFFF8000.
- Run 10 executions (HIST_DEPTH=8) with results 1..10 -> cnt=8, newest shows 10. Older x7 shows 3; older again stays at 3; newer x9 stops at 10.
- Abort and advance in the same cycle in S_LOAD_B -> S_LOAD_A, port_b unchanged. Abort during S_EXEC -> entry still written, S_SHOW entered.
- nRST pulsed low asynchronously in S_SHOW with cnt=5 -> immediately S_LOAD_A, cnt=0, ports 0, led_* 0.
